// File: rtl/pretu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pretu_pkg                                                       |
// | Purpose  : Shared constants and types for the Winograd pre-transform tile  |
// |            feeder (tile geometry, FSM state encoding, default pixel width).|
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package pretu_pkg;

  // 4x4 tiles taken with a step of 2 pixels in both directions
  localparam int TILE       = 4;
  localparam int STRIDE     = 2;
  localparam int DW_DEFAULT = 16;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    EMIT = 1'b1
  } pretu_state_e;

endpackage
`default_nettype wire

// File: rtl/pretu_row_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pretu_row_buf                                                   |
// | Purpose  : Four-slot row store for the tile feeder. Image row r lives in   |
// |            slot r mod 4. Contents are never reset.                         |
// | Ports    : clk              - clock                                        |
// |            wr_en/slot/col   - single write port                            |
// |            wr_data          - pixel to store                               |
// |            rd_rot           - slot of tile row 0 (band_r mod 4)            |
// |            rd_col           - common read column                           |
// |            rd_data[k]       - slot[(rd_rot+k) mod 4][rd_col], comb.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pretu_row_buf
  import pretu_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int IMG_W = 8,
  parameter int CW    = $clog2(IMG_W)
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [1:0]              wr_slot,
  input  logic [CW-1:0]           wr_col,
  input  logic [DW-1:0]           wr_data,
  input  logic [1:0]              rd_rot,
  input  logic [CW-1:0]           rd_col,
  output logic [TILE-1:0][DW-1:0] rd_data
);

  logic [DW-1:0] r_mem [TILE][IMG_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_slot][wr_col] <= wr_data;
    end
  end

  // The 2-bit slot index wraps naturally, giving the mod-4 rotation for free
  for (genvar k = 0; k < TILE; k++) begin : g_rd
    logic [1:0] w_slot;
    assign w_slot     = rd_rot + 2'(k);
    assign rd_data[k] = r_mem[w_slot][rd_col];
  end

endmodule
`default_nettype wire

// File: rtl/pretu_tile_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pretu_tile_feeder                                               |
// | Purpose  : Buffers a raster pixel stream four rows deep and replays it as  |
// |            overlapping 4x4 tiles (stride 2) in column-vector beats that    |
// |            feed the X0..X3 operands of the 1-D Winograd pre-transform.     |
// | Ports    : clk, rst_n (async, active-low)                                  |
// |            in_valid/in_ready/in_data     - pixel input stream              |
// |            out_valid/out_ready           - beat handshake                  |
// |            out_x0..out_x3                - tile rows 0..3, current column  |
// |            out_first/out_last            - beat 0 / beat 3 of a tile       |
// |            out_frame_last                - final beat of the frame         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pretu_tile_feeder
  import pretu_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int IMG_W = 8,
  parameter int IMG_H = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_x0,
  output logic [DW-1:0] out_x1,
  output logic [DW-1:0] out_x2,
  output logic [DW-1:0] out_x3,
  output logic          out_first,
  output logic          out_last,
  output logic          out_frame_last
);

  localparam int CW = $clog2(IMG_W);
  // Row counter must reach IMG_H once the final band is filled
  localparam int RW = $clog2(IMG_H + 1);
  localparam int BW = $clog2(TILE);

  localparam logic [CW-1:0] c_last_col  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] c_last_tile = CW'(IMG_W - TILE);
  localparam logic [RW-1:0] c_last_band = RW'(IMG_H - TILE);
  localparam logic [BW-1:0] c_last_beat = BW'(TILE - 1);

  pretu_state_e            r_state;
  logic [CW-1:0]           r_in_col;
  logic [RW-1:0]           r_in_row;
  logic [RW-1:0]           r_band_r;
  logic [CW-1:0]           r_tile_c;
  logic [BW-1:0]           r_beat_b;
  logic                    r_out_valid;
  logic [TILE-1:0][DW-1:0] r_x;
  logic                    r_first;
  logic                    r_last;
  logic                    r_frame_last;

  logic                    w_accept;
  logic                    w_fire;
  logic                    w_fill_done;
  logic                    w_final_beat;
  logic                    w_final_band;
  logic [BW-1:0]           w_next_b;
  logic [CW-1:0]           w_next_c;
  logic [CW-1:0]           w_rd_col;
  logic [TILE-1:0][DW-1:0] w_rd_data;

  // Gated by rst_n so in_ready is low for the whole reset and high on the
  // very first cycle after release.
  assign in_ready     = (r_state == FILL) && rst_n;
  assign w_accept     = in_valid && in_ready;
  assign w_fire       = r_out_valid && out_ready;
  assign w_fill_done  = w_accept && (r_in_col == c_last_col) &&
                        (r_in_row == r_band_r + RW'(TILE - 1));
  assign w_final_beat = (r_beat_b == c_last_beat) && (r_tile_c == c_last_tile);
  assign w_final_band = (r_band_r == c_last_band);

  // Beat that the output register loads next. In FILL that is always the
  // band's first beat (column 0), so the read column is prefetched before
  // the band completes and out_valid can rise with no extra cycle.
  always_comb begin
    w_next_b = '0;
    w_next_c = '0;
    if (r_state == EMIT) begin
      if (r_beat_b == c_last_beat) begin
        w_next_c = r_tile_c + CW'(STRIDE);
      end else begin
        w_next_b = r_beat_b + 1'b1;
        w_next_c = r_tile_c;
      end
    end
    w_rd_col = w_next_c + CW'(w_next_b);
  end

  pretu_row_buf #(
    .DW    (DW),
    .IMG_W (IMG_W),
    .CW    (CW)
  ) u_row_buf (
    .clk     (clk),
    .wr_en   (w_accept),
    .wr_slot (r_in_row[1:0]),
    .wr_col  (r_in_col),
    .wr_data (in_data),
    .rd_rot  (r_band_r[1:0]),
    .rd_col  (w_rd_col),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FILL;
      r_in_col     <= '0;
      r_in_row     <= '0;
      r_band_r     <= '0;
      r_tile_c     <= '0;
      r_beat_b     <= '0;
      r_out_valid  <= 1'b0;
      r_x          <= '0;
      r_first      <= 1'b0;
      r_last       <= 1'b0;
      r_frame_last <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_accept) begin
            if (r_in_col == c_last_col) begin
              r_in_col <= '0;
              r_in_row <= r_in_row + 1'b1;
            end else begin
              r_in_col <= r_in_col + 1'b1;
            end
            if (w_fill_done) begin
              r_state      <= EMIT;
              r_out_valid  <= 1'b1;
              r_tile_c     <= '0;
              r_beat_b     <= '0;
              r_x          <= w_rd_data;
              r_first      <= 1'b1;
              r_last       <= 1'b0;
              r_frame_last <= 1'b0;
            end
          end
        end
        EMIT: begin
          if (w_fire) begin
            if (w_final_beat) begin
              r_state     <= FILL;
              r_out_valid <= 1'b0;
              if (w_final_band) begin
                r_band_r <= '0;
                r_in_row <= '0;
              end else begin
                // Oldest two slots are free; the next two rows land there
                r_band_r <= r_band_r + RW'(STRIDE);
              end
            end else begin
              r_tile_c     <= w_next_c;
              r_beat_b     <= w_next_b;
              r_x          <= w_rd_data;
              r_first      <= (w_next_b == '0);
              r_last       <= (w_next_b == c_last_beat);
              r_frame_last <= (w_next_b == c_last_beat) &&
                              (w_next_c == c_last_tile) && w_final_band;
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign out_valid      = r_out_valid;
  assign out_x0         = r_x[0];
  assign out_x1         = r_x[1];
  assign out_x2         = r_x[2];
  assign out_x3         = r_x[3];
  assign out_first      = r_first;
  assign out_last       = r_last;
  assign out_frame_last = r_frame_last;

endmodule
`default_nettype wire

// File: tb/tb_pretu_tile_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pretu_tile_feeder                                            |
// | Purpose  : Self-checking bench for pretu_tile_feeder. Frames are described |
// |            as whole images; expected beats are enumerated directly from   |
// |            the tile geometry and compared on every valid cycle.           |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_pretu_tile_feeder;

  localparam int DW    = 16;
  localparam int IMG_W = 8;
  localparam int IMG_H = 6;
  localparam int BEATS_PER_BAND = 2 * (IMG_W - 2);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_x0, out_x1, out_x2, out_x3;
  logic          out_first, out_last, out_frame_last;

  always #5 clk = ~clk;

  pretu_tile_feeder #(
    .DW    (DW),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_x0         (out_x0),
    .out_x1         (out_x1),
    .out_x2         (out_x2),
    .out_x3         (out_x3),
    .out_first      (out_first),
    .out_last       (out_last),
    .out_frame_last (out_frame_last)
  );

  typedef struct packed {
    logic [63:0] data;   // {x0, x1, x2, x3}
    logic [2:0]  flags;  // {first, last, frame_last}
  } beat_t;

  logic [DW-1:0] pix_q[$];
  beat_t         exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int k_pix = 0;       // pixels accepted within the current frame
  int avail = 0;       // beats released to the output but not yet consumed
  int beats_done = 0;
  int stall_cnt = 0;
  int gap_mode = 0;    // 0: always valid, 1: every other cycle, 2: random
  int rdy_pct = 100;
  int stall_at = -1;
  int stall_len = 0;
  int rst_at = -1;
  bit tog = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Whole-frame reference: every tile of every band, column by column.
  task automatic load_frame(input bit rnd);
    logic [DW-1:0] img [IMG_H][IMG_W];
    beat_t be;
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        img[r][c] = rnd ? DW'($urandom) : DW'(16 * r + c);
        pix_q.push_back(img[r][c]);
      end
    end
    for (int br = 0; br <= IMG_H - 4; br += 2) begin
      for (int c = 0; c <= IMG_W - 4; c += 2) begin
        for (int b = 0; b < 4; b++) begin
          be.data  = {img[br][c+b], img[br+1][c+b], img[br+2][c+b], img[br+3][c+b]};
          be.flags = {b == 0, b == 3, (b == 3) && (c == IMG_W - 4) && (br == IMG_H - 4)};
          exp_q.push_back(be);
        end
      end
    end
  endtask

  task automatic cycle();
    bit exp_rdy;
    bit iv;
    int row, col;
    @(negedge clk);
    exp_rdy = (avail == 0);
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, avail > 0);
    if (avail > 0) begin
      check("beat_data", {out_x0, out_x1, out_x2, out_x3}, exp_q[0].data);
      check("beat_flags", {out_first, out_last, out_frame_last}, exp_q[0].flags);
    end
    out_ready = ($urandom_range(99) < rdy_pct);
    if (stall_at >= 0 && beats_done == stall_at && stall_cnt < stall_len) begin
      out_ready = 1'b0;
      stall_cnt++;
    end
    if (avail > 0 && out_ready) begin
      void'(exp_q.pop_front());
      avail--;
      beats_done++;
    end
    case (gap_mode)
      0:       iv = 1'b1;
      1:       begin iv = tog; tog = ~tog; end
      default: iv = ($urandom_range(3) != 0);
    endcase
    if (pix_q.size() == 0) iv = 1'b0;
    in_valid = iv;
    if (iv) in_data = pix_q[0];
    else    in_data = DW'($urandom);
    if (iv && exp_rdy) begin
      void'(pix_q.pop_front());
      row = k_pix / IMG_W;
      col = k_pix % IMG_W;
      k_pix++;
      if (col == IMG_W - 1 && row >= 3 && (row % 2) == 1) avail += BEATS_PER_BAND;
      if (k_pix == IMG_W * IMG_H) k_pix = 0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_data"}, {out_x0, out_x1, out_x2, out_x3}, 64'd0);
    check({tag, "_flags"}, {out_first, out_last, out_frame_last}, 3'd0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    pix_q.delete();
    exp_q.delete();
    k_pix = 0;
    avail = 0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int budget);
    int  n;
    bit  done;
    n = 0;
    beats_done = 0;
    stall_cnt = 0;
    while ((pix_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      cycle();
      n++;
      if (rst_at >= 0 && beats_done == rst_at && avail > 0) begin
        mid_reset();
        return;
      end
    end
    done = (pix_q.size() == 0) && (exp_q.size() == 0);
    check("run_done", done, 1'b1);
    if (!done) begin
      pix_q.delete();
      exp_q.delete();
      avail = 0;
    end
    cycle();  // out_valid must have dropped, in_ready risen
  endtask

  initial begin
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Plain frame, full throughput
    load_frame(1'b0);
    run(2000);

    // Backpressure held at band 0 beat 2
    stall_at = 2; stall_len = 5;
    load_frame(1'b0);
    run(2000);
    stall_at = -1;

    // in_valid toggling during FILL
    gap_mode = 1;
    load_frame(1'b0);
    run(2000);
    gap_mode = 0;

    // Reset while band 0 beat 5 is presented, then a fresh frame
    rst_at = 5;
    load_frame(1'b0);
    run(2000);
    rst_at = -1;
    load_frame(1'b0);
    run(2000);

    // Two frames back to back
    load_frame(1'b0);
    load_frame(1'b0);
    run(4000);

    // Random pixels, random input gaps and output stalls
    gap_mode = 2; rdy_pct = 60;
    for (int i = 0; i < 3; i++) load_frame(1'b1);
    run(8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
